membus_dbg_master: RTL and testbench

- Debug-side bus initiator. Turns host commands (single or burst word read/write) into Membus requests and returns one response per beat.
- Sits between a host/debug command source and a Membus slave port, e.g. an extra mmio_controller request port, or a memory driven directly in a bench.
- Drives the request side of Membus (valid/addr/wen/wdata/wmask) and consumes the response side (ready/rvalid/rdata).
- At most one request is outstanding. A timeout watchdog protects against slaves that never respond.

---
 rtl/membus_dbg_master.sv | 136 +++++++++++++
 tb/tb_membus_dbg_master.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_dbg_master.sv
// Debug-side Membus initiator: single/burst word commands become one
// request per beat with a watchdog guarding against silent slaves.
module membus_dbg_master #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_wen,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wmask,
    input  logic [7:0]              cmd_len,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    resp_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_wen,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    busy,
    output logic [15:0]             timeout_cnt
);

    localparam int STRB = DATA_WIDTH / 8;
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB-1:0]       wmask;
    logic [7:0]            beats_left;
    logic [TW-1:0]         timer;
    logic                  stale;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign m_valid    = (state == REQ);
    assign m_addr     = addr;
    assign m_wen      = wen;
    assign m_wdata    = wdata;
    assign m_wmask    = wmask;
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign resp_last  = resp_valid && ((beats_left == 8'd0) || err_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr        <= '0;
            wen         <= 1'b0;
            wdata       <= '0;
            wmask       <= '0;
            beats_left  <= 8'd0;
            timer       <= '0;
            stale       <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timeout_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        wen        <= cmd_wen;
                        wdata      <= cmd_wdata;
                        wmask      <= cmd_wmask;
                        beats_left <= cmd_len;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (m_rvalid && stale)
                        stale <= 1'b0;
                    if (m_ready) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A stale rvalid answers an earlier timed-out beat
                    if (m_rvalid && stale) begin
                        stale <= 1'b0;
                        timer <= '0;
                    end else if (m_rvalid) begin
                        rdata_q <= wen ? '0 : m_rdata;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else if (timer == TMAX) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        stale   <= 1'b1;
                        if (timeout_cnt != 16'hFFFF)
                            timeout_cnt <= timeout_cnt + 16'd1;
                        state   <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (m_rvalid && stale)
                        stale <= 1'b0;
                    if (resp_ready) begin
                        if (resp_last) begin
                            state <= IDLE;
                        end else begin
                            addr       <= addr + ADDR_WIDTH'(STRB);
                            beats_left <= beats_left - 8'd1;
                            state      <= REQ;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_dbg_master.sv
// Randomized bench for membus_dbg_master: bench-side slave and host,
// transaction-level reference model and per-cycle output comparison.
module tb_membus_dbg_master;

    localparam int TO = 16;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [7:0]  len;
    } cmd_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        last;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wen;
    logic [63:0] cmd_addr, cmd_wdata;
    logic [7:0]  cmd_wmask, cmd_len;
    logic        resp_valid, resp_ready, resp_err, resp_last;
    logic [63:0] resp_rdata;
    logic        m_valid, m_ready, m_wen, m_rvalid;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_wmask;
    logic        busy;
    logic [15:0] timeout_cnt;

    always #5 clk = ~clk;

    membus_dbg_master #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wen(cmd_wen),
        .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask), .cmd_len(cmd_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_last(resp_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_of(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // stimulus knobs
    int          rdy_pct = 100, rr_pct = 100, gap_pct = 0;
    int          stall_n = 0, rstall_n = 0;
    int          lat_min = 1, lat_max = 1;
    bit          mute = 0, stale_pre = 0, fix_en = 0;
    logic [63:0] fix_data = '0;
    cmd_t        cmd_q[$];

    // observation logs for directed literal checks
    logic [63:0] acc_log[$];
    rsp_t        rsp_log[$];
    int          acc_edge = 0, rise_edge = 0;
    bit          rv_prev = 0;

    // reference model state
    bit   active = 0, waiting = 0, rv_exp = 0, stale_m = 0;
    int   wait_cnt = 0, errs = 0;
    req_t exp_req[$];
    req_t cur;
    rsp_t rsp_e;

    always @(negedge clk) begin : cmp
        bit mv_exp, a0, w0;
        cyc++;
        a0 = active;
        w0 = waiting;
        mv_exp = active && !waiting && !rv_exp;
        chk("cmd_ready", 64'(cmd_ready), 64'(!active));
        chk("busy", 64'(busy), 64'(active));
        chk("m_valid", 64'(m_valid), 64'(mv_exp));
        chk("resp_valid", 64'(resp_valid), 64'(rv_exp));
        chk("timeout_cnt", 64'(timeout_cnt), 64'(errs));
        if (mv_exp && exp_req.size() > 0) begin
            chk("m_addr", m_addr, exp_req[0].addr);
            chk("m_wen", 64'(m_wen), 64'(exp_req[0].wen));
            chk("m_wdata", m_wdata, exp_req[0].wdata);
            chk("m_wmask", 64'(m_wmask), 64'(exp_req[0].wmask));
        end
        if (rv_exp) begin
            chk("resp_rdata", resp_rdata, rsp_e.rdata);
            chk("resp_err", 64'(resp_err), 64'(rsp_e.err));
            chk("resp_last", 64'(resp_last), 64'(rsp_e.last));
        end
        if (resp_valid && !rv_prev)
            rise_edge = cyc;
        rv_prev = resp_valid;

        if (!rst) begin
            active = 0; waiting = 0; rv_exp = 0; stale_m = 0;
            errs = 0; exp_req.delete();
        end else begin
            if (m_rvalid && a0 && !w0)
                stale_m = 0;
            if (rv_exp && resp_ready) begin
                rsp_log.push_back(rsp_e);
                rv_exp = 0;
                if (rsp_e.last) begin
                    active = 0;
                    exp_req.delete();
                end
            end
            if (mv_exp && m_ready) begin
                cur = exp_req.pop_front();
                acc_log.push_back(cur.addr);
                acc_edge = cyc + 1;
                waiting  = 1;
                wait_cnt = 0;
            end else if (w0) begin
                if (m_rvalid && stale_m) begin
                    stale_m  = 0;
                    wait_cnt = 0;
                end else if (m_rvalid) begin
                    rsp_e = '{rdata: cur.wen ? 64'd0 : m_rdata, err: 1'b0,
                              last: exp_req.size() == 0};
                    rv_exp  = 1;
                    waiting = 0;
                end else if (wait_cnt == TO - 1) begin
                    rsp_e   = '{rdata: 64'd0, err: 1'b1, last: 1'b1};
                    rv_exp  = 1;
                    waiting = 0;
                    stale_m = 1;
                    if (errs < 65535) errs++;
                end else begin
                    wait_cnt++;
                end
            end
            if (cmd_valid && !a0) begin
                for (int i = 0; i <= int'(cmd_len); i++)
                    exp_req.push_back('{addr: cmd_addr + 64'(i * 8),
                                        wen: cmd_wen, wdata: cmd_wdata,
                                        wmask: cmd_wmask});
                active = 1;
            end
        end
    end

    // host and slave driver: decide at negedge, drive just after posedge
    initial begin : drv
        int          cd, jcd, sc, rsc;
        bit          acc, chs, rs;
        logic [63:0] pa;
        cd = 0; jcd = 0; sc = 0; rsc = 0; pa = '0;
        cmd_valid = 0; cmd_addr = '0; cmd_wen = 0; cmd_wdata = '0;
        cmd_wmask = '0; cmd_len = '0; resp_ready = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        forever begin
            @(negedge clk);
            acc = m_valid && m_ready;
            chs = cmd_valid && cmd_ready;
            rs  = rst;
            if (acc) pa = m_addr;
            @(posedge clk);
            #1;
            m_rvalid = 0;
            m_rdata  = '0;
            if (!rs) begin
                cd = 0; jcd = 0; sc = 0; rsc = 0;
            end else begin
                if (chs && cmd_q.size() > 0) void'(cmd_q.pop_front());
                if (acc) begin
                    cd = mute ? 0 : int'($urandom_range(lat_max, lat_min));
                    if (stale_pre && !mute) begin
                        jcd = 1; cd = 3; stale_pre = 0;
                    end
                end
                if (jcd > 0) begin
                    jcd--;
                    if (jcd == 0) begin
                        m_rvalid = 1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_rvalid = 1;
                        m_rdata  = fix_en ? fix_data : rd_of(pa);
                    end
                end
            end
            if (cmd_q.size() > 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
                cmd_valid = 1;
                cmd_addr  = cmd_q[0].addr;  cmd_wen   = cmd_q[0].wen;
                cmd_wdata = cmd_q[0].wdata; cmd_wmask = cmd_q[0].wmask;
                cmd_len   = cmd_q[0].len;
            end else begin
                cmd_valid = 0;
            end
            if (stall_n > 0) begin
                m_ready = 0;
                if (m_valid) begin
                    if (sc < stall_n) sc++;
                    else begin m_ready = 1; sc = 0; end
                end
            end else begin
                m_ready = int'($urandom_range(99, 0)) < rdy_pct;
            end
            if (rstall_n > 0) begin
                resp_ready = 0;
                if (resp_valid) begin
                    if (rsc < rstall_n) rsc++;
                    else begin resp_ready = 1; rsc = 0; end
                end
            end else begin
                resp_ready = int'($urandom_range(99, 0)) < rr_pct;
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic w,
                        input logic [63:0] d, input logic [7:0] m,
                        input logic [7:0] l);
        cmd_q.push_back('{addr: a, wen: w, wdata: d, wmask: m, len: l});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(posedge clk); #2;
        while ((cmd_q.size() > 0 || active) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL wait_done: command not finished after %0d cycles", budget);
        end
        repeat (2) begin @(posedge clk); #2; end
    endtask

    task automatic clr_logs();
        acc_log.delete();
        rsp_log.delete();
    endtask

    initial begin : main
        logic [63:0] ea[4];
        logic [63:0] a;
        rst = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset m_valid", 64'(m_valid), 64'd0);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_last", 64'(resp_last), 64'd0);
        chk("reset timeout_cnt", 64'(timeout_cnt), 64'd0);
        rst = 1;

        // single read
        fix_en = 1; fix_data = 64'h1122_3344_5566_7788;
        clr_logs();
        send(64'h8000_0000, 0, '0, 8'h00, 8'd0);
        wait_done(100);
        fix_en = 0;
        chk("single acc count", 64'(acc_log.size()), 64'd1);
        chk("single rsp count", 64'(rsp_log.size()), 64'd1);
        if (rsp_log.size() >= 1) begin
            chk("single rdata", rsp_log[0].rdata, 64'h1122_3344_5566_7788);
            chk("single err", 64'(rsp_log[0].err), 64'd0);
            chk("single last", 64'(rsp_log[0].last), 64'd1);
        end
        chk("single busy", 64'(busy), 64'd0);

        // burst write with request backpressure
        stall_n = 2;
        clr_logs();
        send(64'h8000_1000, 1, 64'hDEAD_BEEF, 8'hFF, 8'd3);
        wait_done(200);
        stall_n = 0;
        ea = '{64'h8000_1000, 64'h8000_1008, 64'h8000_1010, 64'h8000_1018};
        chk("burst acc count", 64'(acc_log.size()), 64'd4);
        chk("burst rsp count", 64'(rsp_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (acc_log.size() > i) chk("burst m_addr", acc_log[i], ea[i]);
            if (rsp_log.size() > i) begin
                chk("burst rdata", rsp_log[i].rdata, 64'd0);
                chk("burst last", 64'(rsp_log[i].last), 64'(i == 3));
            end
        end

        // response stall
        rstall_n = 5;
        clr_logs();
        send(64'h8000_2000, 0, '0, 8'h00, 8'd1);
        wait_done(200);
        rstall_n = 0;
        chk("rstall rsp count", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() >= 2) begin
            chk("rstall rdata0", rsp_log[0].rdata, rd_of(64'h8000_2000));
            chk("rstall rdata1", rsp_log[1].rdata, rd_of(64'h8000_2008));
            chk("rstall last0", 64'(rsp_log[0].last), 64'd0);
        end

        // timeout, then a late rvalid that must be discarded
        mute = 1;
        clr_logs();
        send(64'h8000_3000, 0, '0, 8'h00, 8'd2);
        wait_done(200);
        mute = 0;
        chk("timeout acc count", 64'(acc_log.size()), 64'd1);
        chk("timeout rsp count", 64'(rsp_log.size()), 64'd1);
        if (rsp_log.size() >= 1) begin
            chk("timeout err", 64'(rsp_log[0].err), 64'd1);
            chk("timeout last", 64'(rsp_log[0].last), 64'd1);
            chk("timeout rdata", rsp_log[0].rdata, 64'd0);
        end
        chk("timeout latency", 64'(rise_edge - acc_edge), 64'd16);
        chk("timeout count", 64'(timeout_cnt), 64'd1);
        stale_pre = 1;
        clr_logs();
        send(64'h8000_4000, 0, '0, 8'h00, 8'd0);
        wait_done(100);
        chk("stale rsp count", 64'(rsp_log.size()), 64'd1);
        if (rsp_log.size() >= 1) begin
            chk("stale rdata", rsp_log[0].rdata, rd_of(64'h8000_4000));
            chk("stale err", 64'(rsp_log[0].err), 64'd0);
        end

        // reset in WAIT of beat 2 of 4
        lat_min = 3; lat_max = 3;
        clr_logs();
        send(64'h8000_5000, 1, 64'h55, 8'h0F, 8'd3);
        begin
            int n = 0;
            while (acc_log.size() < 2 && n < 200) begin
                @(posedge clk); #2; n++;
            end
            if (n >= 200) begin
                tests++; fails++;
                $display("FAIL reset wait: beat 2 never accepted");
            end
        end
        rst = 0;
        @(posedge clk); #2;
        rst = 1;
        chk("rst m_valid", 64'(m_valid), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst timeout_cnt", 64'(timeout_cnt), 64'd0);
        lat_min = 1; lat_max = 1;
        clr_logs();
        send(64'h8000_6000, 0, '0, 8'h00, 8'd1);
        wait_done(100);
        chk("post-rst rsp count", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() >= 2)
            chk("post-rst rdata", rsp_log[1].rdata, rd_of(64'h8000_6008));

        // address wrap
        clr_logs();
        send(64'hFFFF_FFFF_FFFF_FFF8, 0, '0, 8'h00, 8'd1);
        wait_done(100);
        chk("wrap acc count", 64'(acc_log.size()), 64'd2);
        if (acc_log.size() >= 2) begin
            chk("wrap addr0", acc_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
            chk("wrap addr1", acc_log[1], 64'd0);
        end

        // randomized traffic
        lat_min = 1; lat_max = 6;
        for (int k = 0; k < 40; k++) begin
            rdy_pct = int'($urandom_range(100, 30));
            rr_pct  = int'($urandom_range(100, 30));
            gap_pct = int'($urandom_range(50, 0));
            a = {$urandom, $urandom} & ~64'h7;
            if ($urandom_range(7, 0) == 0) a = 64'hFFFF_FFFF_FFFF_FFE0;
            send(a, 1'($urandom_range(1, 0)), {$urandom, $urandom},
                 8'($urandom), ($urandom_range(1, 0) == 1)
                     ? 8'($urandom_range(3, 0)) : 8'($urandom_range(15, 0)));
            wait_done(3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
